// File: rtl/ddr_axi_pkg.sv
// Shared constants, state encoding and helpers for the DDR AXI4 burst initiator.
package ddr_axi_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned PAGE_BYTES = 4096;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_AW   = 3'd1;
    localparam logic [STATE_W-1:0] ST_W    = 3'd2;
    localparam logic [STATE_W-1:0] ST_B    = 3'd3;
    localparam logic [STATE_W-1:0] ST_AR   = 3'd4;
    localparam logic [STATE_W-1:0] ST_R    = 3'd5;
    localparam logic [STATE_W-1:0] ST_FAIL = 3'd6;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // True when a burst of len+1 words starting at this page offset runs past the page end.
    function automatic logic crosses_page(input logic [11:0] offset, input logic [7:0] len);
        logic [12:0] span_end;
        span_end = 13'(offset) + {3'b000, len, 2'b00} + 13'd4;
        return span_end > 13'(PAGE_BYTES);
    endfunction

endpackage

// File: rtl/ddr_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator for the board DDR port.
// Requests are registered onto AW/AR; W and R beats pass straight through.
module ddr_axi_burst_master
    import ddr_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0,
    parameter logic [3:0] CACHE  = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,

    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        wr_valid,
    output logic        wr_ready,

    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        rd_valid,
    input  logic        rd_ready,

    output logic        done_valid,
    output logic        done_err,

    output logic [3:0]  ddr_awid,
    output logic [31:0] ddr_awaddr,
    output logic [7:0]  ddr_awlen,
    output logic [2:0]  ddr_awsize,
    output logic [1:0]  ddr_awburst,
    output logic        ddr_awlock,
    output logic [3:0]  ddr_awcache,
    output logic [2:0]  ddr_awprot,
    output logic [3:0]  ddr_awqos,
    output logic        ddr_awvalid,
    input  logic        ddr_awready,

    output logic [31:0] ddr_wdata,
    output logic [3:0]  ddr_wstrb,
    output logic        ddr_wlast,
    output logic        ddr_wvalid,
    input  logic        ddr_wready,

    input  logic [3:0]  ddr_bid,
    input  logic [1:0]  ddr_bresp,
    input  logic        ddr_bvalid,
    output logic        ddr_bready,

    output logic [3:0]  ddr_arid,
    output logic [31:0] ddr_araddr,
    output logic [7:0]  ddr_arlen,
    output logic [2:0]  ddr_arsize,
    output logic [1:0]  ddr_arburst,
    output logic        ddr_arlock,
    output logic [3:0]  ddr_arcache,
    output logic [2:0]  ddr_arprot,
    output logic [3:0]  ddr_arqos,
    output logic        ddr_arvalid,
    input  logic        ddr_arready,

    input  logic [3:0]  ddr_rid,
    input  logic [31:0] ddr_rdata,
    input  logic [1:0]  ddr_rresp,
    input  logic        ddr_rlast,
    input  logic        ddr_rvalid,
    output logic        ddr_rready
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [31:0]        addr_q;
    logic [7:0]         len_q;
    logic [7:0]         beat_cnt;
    logic               err_acc;

    logic accept;
    logic in_w;
    logic in_r;
    logic w_hs;
    logic r_hs;
    logic b_hs;
    logic r_beat_err;
    logic unused_resp_bits;

    assign accept = (state == ST_IDLE) && req_valid && req_ready;
    assign in_w   = (state == ST_W);
    assign in_r   = (state == ST_R);
    assign w_hs   = in_w && wr_valid && ddr_wready;
    assign r_hs   = in_r && ddr_rvalid && rd_ready;
    assign b_hs   = (state == ST_B) && ddr_bready && ddr_bvalid;

    assign unused_resp_bits = ^{req_addr[1:0], ddr_bresp[0], ddr_rresp[0]};

    // Fixed AXI attributes; address and length come only from registers.
    assign ddr_awid    = AXI_ID;
    assign ddr_awaddr  = addr_q;
    assign ddr_awlen   = len_q;
    assign ddr_awsize  = AXI_SIZE_4B;
    assign ddr_awburst = AXI_BURST_INCR;
    assign ddr_awlock  = 1'b0;
    assign ddr_awcache = CACHE;
    assign ddr_awprot  = 3'b000;
    assign ddr_awqos   = 4'h0;
    assign ddr_arid    = AXI_ID;
    assign ddr_araddr  = addr_q;
    assign ddr_arlen   = len_q;
    assign ddr_arsize  = AXI_SIZE_4B;
    assign ddr_arburst = AXI_BURST_INCR;
    assign ddr_arlock  = 1'b0;
    assign ddr_arcache = CACHE;
    assign ddr_arprot  = 3'b000;
    assign ddr_arqos   = 4'h0;

    // Zero-latency data paths, gated so nothing leaks outside W / R.
    assign ddr_wdata  = wr_data;
    assign ddr_wstrb  = wr_strb;
    assign ddr_wvalid = in_w && wr_valid;
    assign ddr_wlast  = in_w && (beat_cnt == len_q);
    assign wr_ready   = in_w && ddr_wready;

    assign rd_data    = ddr_rdata;
    assign rd_valid   = in_r && ddr_rvalid;
    assign rd_last    = in_r && ddr_rlast;
    assign ddr_rready = in_r && rd_ready;

    assign r_beat_err = ddr_rresp[1] || (ddr_rid != AXI_ID)
                     || (ddr_rlast && (beat_cnt != len_q))
                     || (!ddr_rlast && (beat_cnt == len_q));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (crosses_page({req_addr[11:2], 2'b00}, req_len)) state_next = ST_FAIL;
                    else if (req_we)                                    state_next = ST_AW;
                    else                                                state_next = ST_AR;
                end
            end
            ST_AW:   if (ddr_awready) state_next = ST_W;
            ST_W:    if (w_hs && ddr_wlast) state_next = ST_B;
            ST_B:    if (b_hs) state_next = ST_IDLE;
            ST_AR:   if (ddr_arready) state_next = ST_R;
            ST_R:    if (r_hs && ddr_rlast) state_next = ST_IDLE;
            ST_FAIL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake flags track the next state so they are valid the cycle a state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready   <= 1'b0;
            ddr_awvalid <= 1'b0;
            ddr_arvalid <= 1'b0;
            ddr_bready  <= 1'b0;
            addr_q      <= 32'h0;
            len_q       <= 8'h0;
            beat_cnt    <= 8'h0;
            err_acc     <= 1'b0;
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
        end else begin
            req_ready   <= (state_next == ST_IDLE);
            ddr_awvalid <= (state_next == ST_AW);
            ddr_arvalid <= (state_next == ST_AR);
            ddr_bready  <= (state_next == ST_B);
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
            if (accept) begin
                addr_q   <= {req_addr[31:2], 2'b00};
                len_q    <= req_len;
                beat_cnt <= 8'h0;
                err_acc  <= 1'b0;
            end
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                err_acc  <= err_acc || r_beat_err;
                if (ddr_rlast) begin
                    done_valid <= 1'b1;
                    done_err   <= err_acc || r_beat_err;
                end
            end
            if (b_hs) begin
                done_valid <= 1'b1;
                done_err   <= ddr_bresp[1] || (ddr_bid != AXI_ID);
            end
            if (state == ST_FAIL) begin
                done_valid <= 1'b1;
                done_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// Directed bench for ddr_axi_burst_master: the bench plays both client and AXI slave.
module tb_ddr_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done_valid, done_err;
    logic [3:0]  ddr_awid, ddr_awcache, ddr_awqos;
    logic [31:0] ddr_awaddr;
    logic [7:0]  ddr_awlen;
    logic [2:0]  ddr_awsize, ddr_awprot;
    logic [1:0]  ddr_awburst;
    logic        ddr_awlock, ddr_awvalid, ddr_awready;
    logic [31:0] ddr_wdata;
    logic [3:0]  ddr_wstrb;
    logic        ddr_wlast, ddr_wvalid, ddr_wready;
    logic [3:0]  ddr_bid;
    logic [1:0]  ddr_bresp;
    logic        ddr_bvalid, ddr_bready;
    logic [3:0]  ddr_arid, ddr_arcache, ddr_arqos;
    logic [31:0] ddr_araddr;
    logic [7:0]  ddr_arlen;
    logic [2:0]  ddr_arsize, ddr_arprot;
    logic [1:0]  ddr_arburst;
    logic        ddr_arlock, ddr_arvalid, ddr_arready;
    logic [3:0]  ddr_rid;
    logic [31:0] ddr_rdata;
    logic [1:0]  ddr_rresp;
    logic        ddr_rlast, ddr_rvalid, ddr_rready;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    ddr_axi_burst_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_err(done_err),
        .ddr_awid(ddr_awid), .ddr_awaddr(ddr_awaddr), .ddr_awlen(ddr_awlen),
        .ddr_awsize(ddr_awsize), .ddr_awburst(ddr_awburst), .ddr_awlock(ddr_awlock),
        .ddr_awcache(ddr_awcache), .ddr_awprot(ddr_awprot), .ddr_awqos(ddr_awqos),
        .ddr_awvalid(ddr_awvalid), .ddr_awready(ddr_awready),
        .ddr_wdata(ddr_wdata), .ddr_wstrb(ddr_wstrb), .ddr_wlast(ddr_wlast),
        .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready),
        .ddr_bid(ddr_bid), .ddr_bresp(ddr_bresp), .ddr_bvalid(ddr_bvalid), .ddr_bready(ddr_bready),
        .ddr_arid(ddr_arid), .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen),
        .ddr_arsize(ddr_arsize), .ddr_arburst(ddr_arburst), .ddr_arlock(ddr_arlock),
        .ddr_arcache(ddr_arcache), .ddr_arprot(ddr_arprot), .ddr_arqos(ddr_arqos),
        .ddr_arvalid(ddr_arvalid), .ddr_arready(ddr_arready),
        .ddr_rid(ddr_rid), .ddr_rdata(ddr_rdata), .ddr_rresp(ddr_rresp),
        .ddr_rlast(ddr_rlast), .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 1; rd_ready = 1;
        ddr_awready = 0; ddr_wready = 1; ddr_bid = 0; ddr_bresp = 0; ddr_bvalid = 1;
        ddr_arready = 0; ddr_rid = 0; ddr_rdata = 0; ddr_rresp = 0; ddr_rlast = 1; ddr_rvalid = 1;
        tick; tick;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if ({ddr_awvalid, ddr_arvalid, ddr_wvalid, ddr_bready, ddr_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_valids got %b want 00000", {ddr_awvalid, ddr_arvalid, ddr_wvalid, ddr_bready, ddr_rready}); end
        checks++; if ({wr_ready, rd_valid, rd_last, done_valid, done_err} !== 5'b0) begin
            errors++; $display("FAIL reset_client_outs got %b want 00000", {wr_ready, rd_valid, rd_last, done_valid, done_err}); end
        wr_valid = 0; rd_ready = 0; ddr_wready = 0; ddr_bvalid = 0; ddr_rlast = 0; ddr_rvalid = 0;
        rst = 1'b0;
        tick;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_write;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_1000; req_len = 8'd3;
        tick;
        req_valid = 0;
        checks++; if (ddr_awvalid !== 1'b1 || ddr_awaddr !== 32'h0000_1000 || ddr_awlen !== 8'd3) begin
            errors++; $display("FAIL wr_aw got valid=%b addr=%h len=%0d want 1 00001000 3", ddr_awvalid, ddr_awaddr, ddr_awlen); end
        checks++; if ({ddr_awid, ddr_awsize, ddr_awburst, ddr_awlock, ddr_awcache, ddr_awprot, ddr_awqos} !== {4'h0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}) begin
            errors++; $display("FAIL wr_aw_fields got %h want %h", {ddr_awid, ddr_awsize, ddr_awburst, ddr_awlock, ddr_awcache, ddr_awprot, ddr_awqos}, {4'h0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}); end
        checks++; if (req_ready !== 1'b0 || ddr_wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_aw_phase got req_ready=%b wvalid=%b want 0 0", req_ready, ddr_wvalid); end
        wr_valid = 1; wr_data = 32'hDEAD; ddr_wready = 1; #1;
        checks++; if (ddr_wvalid !== 1'b0 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL wr_w_before_aw got wvalid=%b wr_ready=%b want 0 0", ddr_wvalid, wr_ready); end
        wr_valid = 0; ddr_wready = 0;
        ddr_awready = 1;
        tick;
        ddr_awready = 0;
        checks++; if (ddr_awvalid !== 1'b0) begin errors++; $display("FAIL wr_aw_drop got %b want 0", ddr_awvalid); end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 32'hA0 + 32'(i); wr_strb = 4'hF; ddr_wready = 1; #1;
            checks++; if (ddr_wvalid !== 1'b1 || ddr_wdata !== 32'hA0 + 32'(i) || ddr_wstrb !== 4'hF || wr_ready !== 1'b1) begin
                errors++; $display("FAIL wr_beat%0d got v=%b d=%h s=%h rdy=%b want 1 %h f 1", i, ddr_wvalid, ddr_wdata, ddr_wstrb, wr_ready, 32'hA0 + 32'(i)); end
            checks++; if (ddr_wlast !== (i == 3)) begin
                errors++; $display("FAIL wr_wlast%0d got %b want %b", i, ddr_wlast, (i == 3)); end
            tick;
        end
        ddr_wready = 1; #1;
        checks++; if (ddr_wvalid !== 1'b0 || ddr_bready !== 1'b1) begin
            errors++; $display("FAIL wr_b_phase got wvalid=%b bready=%b want 0 1", ddr_wvalid, ddr_bready); end
        wr_valid = 0; ddr_wready = 0;
        ddr_bvalid = 1; ddr_bresp = 2'b00; ddr_bid = 4'h0;
        tick;
        ddr_bvalid = 0;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_done got v=%b e=%b rdy=%b want 1 0 1", done_valid, done_err, req_ready); end
        tick;
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b want 0", done_valid); end
    endtask

    task automatic test_read_stalls;
        int k;
        int cyc;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_2000; req_len = 8'd7;
        tick;
        req_valid = 0;
        tick;
        checks++; if (ddr_arvalid !== 1'b1 || ddr_araddr !== 32'h0000_2000 || ddr_arlen !== 8'd7 || ddr_awvalid !== 1'b0) begin
            errors++; $display("FAIL rd_ar got v=%b addr=%h len=%0d awv=%b want 1 00002000 7 0", ddr_arvalid, ddr_araddr, ddr_arlen, ddr_awvalid); end
        ddr_arready = 1;
        tick;
        ddr_arready = 0;
        k = 0; cyc = 0;
        while (k < 8 && cyc < 400) begin
            ddr_rvalid = ($urandom_range(0, 2) != 0);
            rd_ready   = ($urandom_range(0, 2) != 0);
            ddr_rdata  = 32'hD0 + 32'(k);
            ddr_rlast  = (k == 7);
            ddr_rresp = 2'b00; ddr_rid = 4'h0;
            #1;
            checks++; if (rd_valid !== ddr_rvalid || ddr_rready !== rd_ready) begin
                errors++; $display("FAIL rd_passthru got rd_valid=%b rready=%b want %b %b", rd_valid, ddr_rready, ddr_rvalid, rd_ready); end
            if (ddr_rvalid && rd_ready) begin
                checks++; if (rd_data !== 32'hD0 + 32'(k) || rd_last !== (k == 7)) begin
                    errors++; $display("FAIL rd_beat%0d got d=%h last=%b want %h %b", k, rd_data, rd_last, 32'hD0 + 32'(k), (k == 7)); end
                k++;
            end
            tick;
            cyc++;
        end
        ddr_rvalid = 0; rd_ready = 0; ddr_rlast = 0;
        checks++; if (k !== 8) begin errors++; $display("FAIL rd_timeout got %0d beats want 8", k); end
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b0) begin
            errors++; $display("FAIL rd_done got v=%b e=%b want 1 0", done_valid, done_err); end
        tick;
    endtask

    task automatic test_page_cross;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0FF8; req_len = 8'd3;
        tick;
        req_valid = 0;
        checks++; if (ddr_awvalid !== 1'b0 || done_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL cross_n1 got awv=%b done=%b rdy=%b want 0 0 0", ddr_awvalid, done_valid, req_ready); end
        tick;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b1 || ddr_awvalid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL cross_done got v=%b e=%b awv=%b rdy=%b want 1 1 0 1", done_valid, done_err, ddr_awvalid, req_ready); end
        tick;
    endtask

    task automatic test_rresp_error;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_3000; req_len = 8'd3;
        tick;
        req_valid = 0;
        ddr_arready = 1;
        tick;
        ddr_arready = 0;
        for (int i = 0; i < 4; i++) begin
            ddr_rvalid = 1; rd_ready = 1; ddr_rid = 4'h0;
            ddr_rdata = 32'hE0 + 32'(i); ddr_rlast = (i == 3);
            ddr_rresp = (i == 1) ? 2'b10 : 2'b00;
            #1;
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hE0 + 32'(i) || done_valid !== 1'b0) begin
                errors++; $display("FAIL rresp_beat%0d got v=%b d=%h done=%b want 1 %h 0", i, rd_valid, rd_data, done_valid, 32'hE0 + 32'(i)); end
            tick;
        end
        ddr_rvalid = 0; rd_ready = 0; ddr_rlast = 0; ddr_rresp = 0;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rresp_done got v=%b e=%b rdy=%b want 1 1 1", done_valid, done_err, req_ready); end
    endtask

    // Issued in the completion cycle of the previous read.
    task automatic test_short_rlast_back_to_back;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_4003; req_len = 8'd3;
        tick;
        req_valid = 0;
        checks++; if (ddr_arvalid !== 1'b1 || ddr_araddr !== 32'h0000_4000 || ddr_arlen !== 8'd3) begin
            errors++; $display("FAIL b2b_ar got v=%b addr=%h len=%0d want 1 00004000 3", ddr_arvalid, ddr_araddr, ddr_arlen); end
        ddr_arready = 1;
        tick;
        ddr_arready = 0;
        ddr_rvalid = 1; rd_ready = 1; ddr_rid = 0; ddr_rresp = 0; ddr_rdata = 32'h11; ddr_rlast = 0;
        tick;
        ddr_rdata = 32'h22; ddr_rlast = 1; #1;
        checks++; if (rd_last !== 1'b1 || rd_data !== 32'h22) begin
            errors++; $display("FAIL short_beat2 got last=%b d=%h want 1 22", rd_last, rd_data); end
        tick;
        ddr_rlast = 0; #1;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL short_done got v=%b e=%b rdy=%b want 1 1 1", done_valid, done_err, req_ready); end
        checks++; if (ddr_rready !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL short_surplus got rready=%b rd_valid=%b want 0 0", ddr_rready, rd_valid); end
        ddr_rvalid = 0; rd_ready = 0;
        tick;
    endtask

    task automatic test_bid_error;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0040; req_len = 8'd0;
        tick;
        req_valid = 0;
        ddr_awready = 1;
        tick;
        ddr_awready = 0;
        wr_valid = 1; wr_data = 32'h55; wr_strb = 4'h3; ddr_wready = 1;
        tick;
        wr_valid = 0; ddr_wready = 0;
        ddr_bvalid = 1; ddr_bid = 4'h5; ddr_bresp = 2'b00;
        tick;
        ddr_bvalid = 0; ddr_bid = 0;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b1) begin
            errors++; $display("FAIL bid_done got v=%b e=%b want 1 1", done_valid, done_err); end
        tick;
    endtask

    task automatic test_reset_mid_burst;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_5000; req_len = 8'd7;
        tick;
        req_valid = 0;
        ddr_awready = 1;
        tick;
        ddr_awready = 0;
        wr_valid = 1; wr_data = 32'hB0; wr_strb = 4'hF; ddr_wready = 1;
        tick;
        wr_data = 32'hB1; rst = 1;
        tick;
        checks++; if ({ddr_awvalid, ddr_arvalid, ddr_wvalid, ddr_bready, ddr_rready} !== 5'b0) begin
            errors++; $display("FAIL midrst_axi got %b want 00000", {ddr_awvalid, ddr_arvalid, ddr_wvalid, ddr_bready, ddr_rready}); end
        checks++; if ({wr_ready, req_ready, done_valid} !== 3'b0) begin
            errors++; $display("FAIL midrst_client got %b want 000", {wr_ready, req_ready, done_valid}); end
        rst = 0; wr_valid = 0; ddr_wready = 0;
        tick;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b want 1", req_ready); end
        // Ends exactly on the page boundary, so this one is legal.
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0FFC; req_len = 8'd0;
        tick;
        req_valid = 0;
        checks++; if (ddr_awvalid !== 1'b1 || ddr_awaddr !== 32'h0000_0FFC || ddr_awlen !== 8'd0) begin
            errors++; $display("FAIL len0_aw got v=%b addr=%h len=%0d want 1 00000ffc 0", ddr_awvalid, ddr_awaddr, ddr_awlen); end
        ddr_awready = 1;
        tick;
        ddr_awready = 0;
        wr_valid = 1; wr_data = 32'hC0; wr_strb = 4'hF; ddr_wready = 1; #1;
        checks++; if (ddr_wvalid !== 1'b1 || ddr_wlast !== 1'b1) begin
            errors++; $display("FAIL len0_wlast got v=%b last=%b want 1 1", ddr_wvalid, ddr_wlast); end
        tick;
        wr_valid = 0; ddr_wready = 0;
        ddr_bvalid = 1; ddr_bresp = 2'b00; ddr_bid = 0;
        tick;
        ddr_bvalid = 0;
        checks++; if (done_valid !== 1'b1 || done_err !== 1'b0) begin
            errors++; $display("FAIL len0_done got v=%b e=%b want 1 0", done_valid, done_err); end
        tick;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_stalls;
        test_page_cross;
        test_rresp_error;
        test_short_rlast_back_to_back;
        test_bid_error;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
